alu_sweep_seq: RTL and testbench

Sequencer stage directly upstream of the 4-bit ALU (`A`, `B`, `ALU_Sel` → `ALU_Out`, `CarryOut`). On a start request it walks a fixed opcode list and, for each opcode, drives all 256 {A,B} operand pairs into the combinational ALU. It folds every returned result into a 16-bit signature, turning the exhaustive ALU sweep into a single-clock, synthesizable self-test. The result is checked against a golden value by software or by a bench.

---
 rtl/alu_sweep_seq.sv | 153 +++++++++++++++
 tb/tb_alu_sweep_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_seq.sv
// Exhaustive ALU self-test sequencer: sweeps every {A,B} pair per opcode and folds results into a 16-bit signature.
// Optional build macro SWEEP_CHECK_EN adds an in-block adder check that drives the sticky err flag.
module alu_sweep_seq #(
  parameter int SETTLE_CYCLES = 20,
  parameter int NUM_OPS       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  ALU_Sel,
  input  logic [3:0]  ALU_Out,
  input  logic        CarryOut,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [2:0]  op_idx,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, GAP, SWEEP, DONE} state_t;

  localparam logic [7:0] GAP_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_OP  = 3'(NUM_OPS - 1);

  state_t      state_reg, state_next;
  logic [3:0]  a_reg, a_next;
  logic [3:0]  b_reg, b_next;
  logic [3:0]  sel_reg, sel_next;
  logic [2:0]  op_idx_reg, op_idx_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [15:0] sig_reg, sig_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  function automatic logic [3:0] opcode_at(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0010;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b1000;
      3'd5:    return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sel_reg     <= '0;
      op_idx_reg  <= '0;
      gap_cnt_reg <= '0;
      sig_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      sel_reg     <= sel_next;
      op_idx_reg  <= op_idx_next;
      gap_cnt_reg <= gap_cnt_next;
      sig_reg     <= sig_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    sel_next     = sel_reg;
    op_idx_next  = op_idx_reg;
    gap_cnt_next = gap_cnt_reg;
    sig_next     = sig_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = GAP;
          sig_next     = '0;
          gap_cnt_next = GAP_LOAD;
          op_idx_next  = '0;
          sel_next     = opcode_at(3'd0);
          a_next       = '0;
          b_next       = '0;
        end
      end
      GAP: begin
        if (gap_cnt_reg == 8'd0) state_next = SWEEP;
        else                     gap_cnt_next = gap_cnt_reg - 8'd1;
      end
      SWEEP: begin
        // The ALU answer for the current registered operands is folded on the edge that advances them.
        sig_next = {sig_reg[14:0], sig_reg[15]} ^ {11'b0, CarryOut, ALU_Out};
        b_next   = b_reg + 4'd1;
        if (b_reg == 4'd15) a_next = a_reg + 4'd1;
        if (a_reg == 4'd15 && b_reg == 4'd15) begin
          if (op_idx_reg < LAST_OP) begin
            op_idx_next  = op_idx_reg + 3'd1;
            sel_next     = opcode_at(op_idx_reg + 3'd1);
            gap_cnt_next = GAP_LOAD;
            state_next   = GAP;
          end else begin
            op_idx_next = '0;
            sel_next    = '0;
            state_next  = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == GAP) || (state_next == SWEEP);
    done_next = (state_next == DONE);
  end

`ifdef SWEEP_CHECK_EN
  logic       err_reg, err_next;
  logic [4:0] ref_sum;

  always_comb begin
    ref_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    err_next = err_reg;
    if (state_reg == IDLE && start)
      err_next = 1'b0;
    else if (state_reg == SWEEP && sel_reg == 4'b0000 && {CarryOut, ALU_Out} != ref_sum)
      err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign A         = a_reg;
  assign B         = b_reg;
  assign ALU_Sel   = sel_reg;
  assign op_idx    = op_idx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign signature = sig_reg;

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Scoreboard bench for alu_sweep_seq: a behavioural ALU plus a loop-based signature model feed an expectation queue.
module tb_alu_sweep_seq;

  localparam int S        = 20;
  localparam int N        = 6;
  localparam int PER      = S + 256;
  localparam int BUSY_LEN = N * PER;
  localparam int NSAMP    = N * 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  A, B, ALU_Sel, ALU_Out;
  logic        CarryOut, busy, done, err;
  logic [15:0] signature;
  logic [2:0]  op_idx;

  int checks = 0;
  int errors = 0;

  // ALU behaviour: 0 correct, 1 constant 1, 2 wrong sum at (3,4) for add, 3 one random corrupted sample
  int         mode = 0;
  int         f_op = 0, f_a = 0, f_b = 0;
  logic [3:0] f_val = 4'h0;

  logic [3:0] op_list [6] = '{4'h0, 4'h2, 4'h4, 4'h7, 4'h8, 4'hE};

  logic [15:0] sig_tr [0:NSAMP];
  logic        err_tr [0:NSAMP];

  typedef struct {
    int          m;
    logic [15:0] sig;
    logic        er;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  alu_sweep_seq #(.SETTLE_CYCLES(S), .NUM_OPS(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
    .busy(busy), .done(done), .signature(signature), .op_idx(op_idx), .err(err)
  );

  function automatic logic [4:0] alu_fn(input int m, input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] t;
    if (m == 1) return 5'h01;
    if (m == 2 && sel == 4'h0 && a == 4'd3 && b == 4'd4) return 5'h08;
    if (m == 3 && sel == op_list[f_op] && int'(a) == f_a && int'(b) == f_b) return {1'b0, f_val};
    case (sel)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h2:    begin t = a - b;   return {1'b0, t}; end
      4'h4:    begin t = a << 1;  return {1'b0, t}; end
      4'h7:    begin t = a ^ b;   return {1'b0, t}; end
      4'h8:    begin t = a & b;   return {1'b0, t}; end
      4'hE:    return (a == b) ? 5'h01 : 5'h00;
      default: return 5'h00;
    endcase
  endfunction

  always_comb {CarryOut, ALU_Out} = alu_fn(mode, ALU_Sel, A, B);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Signature after every completed sample, straight from the fold rule over the sweep order.
  task automatic build_model();
    logic [15:0] s;
    logic        e;
    logic [4:0]  r;
    int          k;
    s = '0; e = 1'b0; k = 0;
    sig_tr[0] = '0; err_tr[0] = 1'b0;
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          r = alu_fn(mode, op_list[i], 4'(a), 4'(b));
          s = {s[14:0], s[15]} ^ {11'b0, r};
`ifdef SWEEP_CHECK_EN
          if (op_list[i] == 4'h0 && int'(r) != a + b) e = 1'b1;
`endif
          k++;
          sig_tr[k] = s;
          err_tr[k] = e;
        end
  endtask

  task automatic do_start();
    exp_t x;
    build_model();
    x.m = mode; x.sig = sig_tr[NSAMP]; x.er = err_tr[NSAMP];
    exp_q.push_back(x);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 4000) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout_%s: got no done after %0d cycles, expected done within 4000", tag, n);
    end
    $display("run %s: mode=%0d signature=%04h err=%0b", tag, mode, signature, err);
    @(posedge clk); #1;
  endtask

  // Monitor: checks every busy cycle against the timing/signature model and pops the scoreboard at done.
  initial begin
    int   c, i, o, k;
    bit   in_run;
    exp_t e;
    logic [3:0] ea, eb;
    c = 0; in_run = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_run = 1'b0;
        c = 0;
      end else if (busy) begin
        if (!in_run) begin
          in_run = 1'b1;
          c = 0;
          chk("busy_rise_has_start", 64'(exp_q.size() > 0), 64'd1);
        end
        i = c / PER;
        o = c % PER;
        if (i < N) begin
          k  = i * 256 + ((o < S) ? 0 : o - S);
          ea = (o < S) ? 4'd0 : 4'((o - S) / 16);
          eb = (o < S) ? 4'd0 : 4'((o - S) % 16);
          chk($sformatf("cycle%0d_state", c),
              64'({op_idx, ALU_Sel, A, B, signature, err, done}),
              64'({3'(i), op_list[i], ea, eb, sig_tr[k], err_tr[k], 1'b0}));
          if (mode == 1 && o == S + 16) chk("stub_sig_after16", 64'(signature), 64'hFFFF);
        end else begin
          chk("busy_overrun", 64'(c), 64'(BUSY_LEN - 1));
        end
        c++;
      end else if (in_run) begin
        in_run = 1'b0;
        chk("busy_len", 64'(c), 64'(BUSY_LEN));
        chk("done_pulse", 64'(done), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("final_sig", 64'(signature), 64'(e.sig));
          chk("final_err", 64'(err), 64'(e.er));
          if (e.m == 1) chk("stub_sig_done", 64'(signature), 64'h0000);
        end
      end else begin
        chk("idle_outputs", 64'({A, B, ALU_Sel, op_idx, busy, done}), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, target;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_reset_sig_err", 64'({signature, err}), 64'd0);

    // Correct ALU, with a stray start pulse somewhere in the middle of the run
    mode = 0;
    do_start();
    repeat ($urandom_range(300, 1500)) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("correct_restart_ignored");

    // Constant-1 stub
    repeat ($urandom_range(2, 20)) @(posedge clk);
    mode = 1;
    do_start();
    wait_done("stub_const1");

    // Reset on the 100th SWEEP cycle of opcode index 2
    mode = 0;
    do_start();
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_after_start", 64'(busy), 64'd1);
    target = 2 * PER + S + 99;
    repeat (target - 1) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_reset_outputs", 64'({A, B, ALU_Sel, op_idx, busy, done, err, signature}), 64'd0);
    $display("run mid_reset: outputs cleared busy=%0b signature=%04h", busy, signature);

    // Fresh run after the interrupted one
    do_start();
    wait_done("after_reset");

    // Wrong add result at (3,4)
    mode = 2;
    do_start();
    wait_done("fault_3p4");

    // Random single-sample corruptions, the first forced onto the add opcode
    for (int r = 0; r < 2; r++) begin
      mode  = 3;
      f_op  = (r == 0) ? 0 : int'($urandom_range(0, N - 1));
      f_a   = int'($urandom_range(0, 15));
      f_b   = int'($urandom_range(0, 15));
      f_val = 4'($urandom_range(0, 15));
      do_start();
      wait_done($sformatf("rand_fault_op%0d_a%0d_b%0d", f_op, f_a, f_b));
    end

    mode = 0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
